// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared divider defaults and divisor clamp rule
package clk_div_pkg;

    localparam int CNT_W_DEF   = 24;
    localparam int DIV_RST_DEF = 1250000;

    // Half-periods of 0 and 1 both mean "toggle every cycle"; this keeps the
    // counter compare from ever waiting on an unreachable value.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - single divided-clock channel with shadowed divisor
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             pend_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(clamp_div(32'(DIV_RST)));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shad_q, shad_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Count, toggle at the end of each half-period, and swap in a pending
    // divisor only on a toggle so no half-period is ever cut short.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        shad_d = shad_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (en_i) begin
            if (cnt_q == half_q) begin
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                cnt_d  = CNT_W'(1);
                if (pend_q) begin
                    half_d = shad_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A load is only taken while nothing is pending, so a load landing on
        // a toggle edge cannot be consumed by that same toggle.
        if (ld_i && !pend_q) begin
            shad_d = CNT_W'(clamp_div(32'(div_i)));
            pend_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_W'(1);
            half_q <= DIV_INIT;
            shad_q <= DIV_INIT;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            shad_q <= shad_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - N-channel clock divider with per-channel divisor load
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  N_CH    = 4,
    parameter int  CNT_W   = CNT_W_DEF,
    parameter int  DIV_RST = DIV_RST_DEF,
    localparam int LD_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld_valid,
    input  logic [LD_W-1:0]  ld_ch,
    input  logic [CNT_W-1:0] ld_div,
    output logic             ld_ready,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0]        pend;
    logic [(1<<LD_W)-1:0]   pend_pad;
    logic                   in_range;

    // Widen the pending flags to the full ld_ch decode space so channel
    // numbers past N_CH index a defined bit.
    always_comb begin
        pend_pad           = '0;
        pend_pad[N_CH-1:0] = pend;
    end

    assign in_range = (32'(ld_ch) < N_CH);
    assign ld_ready = in_range & ~pend_pad[ld_ch];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = ld_valid & ld_ready & (32'(ld_ch) == i);

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en),
            .ld_i      (sel),
            .div_i     (ld_div),
            .pend_o    (pend[i]),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i])
        );
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent divided-clock channels, range 1..8.
REQ-002 Parameter CNT_W, default 24: width of the half-period divisor and of the channel counters.
REQ-003 Parameter DIV_RST, default 1250000: half-period (in clk cycles) loaded into every channel on reset (40 Hz from 100 MHz).
REQ-004 clk  in  1  system clock (100 MHz); all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  global count enable; low freezes all counters and outputs.
REQ-007 ld_valid  in  1  divisor load request.
REQ-008 ld_ch  in  clog2(N_CH) (min 1)  target channel of the load.
REQ-009 ld_div  in  CNT_W  requested half-period in clk cycles.
REQ-010 ld_ready  out  1  load can be accepted for ld_ch this cycle.
REQ-011 clk_out  out  N_CH  per-channel 50 %-duty divided clock.
REQ-012 tick  out  N_CH  per-channel one-cycle pulse coincident with each clk_out toggle.

Function
REQ-013 Each channel SHALL hold an active half-period H, a counter C (1..H), a shadow divisor S and a pending flag P.
REQ-014 With en=1, C SHALL increment by 1 per cycle; when C==H the channel SHALL toggle clk_out, pulse tick for exactly one cycle, and set C=1.
REQ-015 Output period SHALL be exactly 2*H clk cycles; H=1 SHALL toggle every cycle.
REQ-016 ld_div values 0 and 1 SHALL both be stored as H=1 (no divide-by-zero, no stall).
REQ-017 ld_ready SHALL equal ~P[ld_ch] combinationally; ld_valid with ld_ready=0 SHALL be ignored with no state change.
REQ-018 Accepted load (ld_valid & ld_ready) SHALL write S and set P of ld_ch on the same edge; other channels unaffected.
REQ-019 A pending divisor SHALL take effect only at the channel's next toggle: on that edge H<=S, C<=1, P<=0 (glitch-free; no shortened half-period).
REQ-020 The half-period in progress at load time SHALL complete with the old H.
REQ-021 Load accepted on the same edge the channel toggles SHALL NOT apply on that edge; it applies at the following toggle.
REQ-022 With en=0: C, clk_out, H unchanged; tick=0; loads still accepted and remain pending until a toggle occurs.
REQ-023 en deasserted then reasserted SHALL resume counting from the frozen C without restart.
REQ-024 ld_ch >= N_CH SHALL report ld_ready=0 and never be accepted.
REQ-025 Channels SHALL be mutually independent; simultaneous toggles on several channels are permitted.

Reset
REQ-026 On rst: clk_out=0, tick=0, C=1, H=S=DIV_RST (0/1 treated per REQ-016), P=0 for every channel, so ld_ready=1.
REQ-027 rst asserted mid-period or with a load pending SHALL discard the pending divisor and restore REQ-026 state.
REQ-028 First toggle after reset release with en=1 SHALL occur DIV_RST cycles after the first active edge.

Structure
REQ-029 CNT_W, DIV_RST and the 0/1 clamp rule SHALL live in a shared parameter include clk_div_pkg, reused by future scan blocks.
REQ-030 One sub-module clk_div_ch (single channel: C, H, S, P, toggle/tick) SHALL be instantiated N_CH times via generate; the top holds only load decode and ld_ready mux.

Verification
REQ-031 Reset, en=1, DIV_RST=4 -> clk_out[0] rises at cycle 4, falls at cycle 8, period 8; tick pulses at 4, 8, 12.
REQ-032 Load ch1 ld_div=2 at cycle 2 of a 4-cycle half-period -> current half-period ends at cycle 4, then toggles every 2; ld_ready for ch1 low from cycle 3 until after that toggle.
REQ-033 ld_div=0 on ch2 -> after apply, clk_out[2] toggles every cycle, tick[2] constantly high.
REQ-034 Second load to ch1 while P[1]=1 -> ignored; ch1 applies first value only; load to ch0 same cycle accepted.
REQ-035 en low for 10 cycles at C=3 (H=4) -> no toggle/tick during gap; toggle occurs 2 cycles after en returns.
REQ-036 rst pulse with ch3 pending ld_div=100 -> all channels restart at DIV_RST, P cleared, ld_ready=1.
